// File: rtl/noc_input_port_requester.sv
// Per-VC request/pop control from input VC buffers toward the five output ports.
// Optional watchdog: define NOC_REQ_TIMEOUT_EN to flag VCs starved of grants.
package noc_req_pkg;
  localparam int Noc_VC_Channel = 4;
endpackage

module noc_input_port_requester
  import noc_req_pkg::*;
#(
  parameter int CHANNELS       = Noc_VC_Channel,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         noc_clk,
  input  logic                         noc_rst_n,
  input  logic [CHANNELS-1:0]          flit_valid_i,
  input  logic [CHANNELS-1:0]          flit_head_i,
  input  logic [CHANNELS-1:0]          flit_tail_i,
  input  logic [CHANNELS-1:0][4:0]     flit_route_i,
  output logic [CHANNELS-1:0]          flit_pop_o,
  output logic [4:0][CHANNELS-1:0]     start_of_packet_o,
  output logic [4:0][CHANNELS-1:0]     request_o,
  input  logic [4:0][CHANNELS-1:0]     grant_i,
  output logic [4:0][CHANNELS-1:0]     free_o,
  output logic [4:0][CHANNELS-1:0]     end_of_packet_o,
  output logic [CHANNELS-1:0]          err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACT  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  logic [CHANNELS-1:0][1:0] state_q, state_d;
  logic [CHANNELS-1:0][4:0] route_q, route_d;
  logic [CHANNELS-1:0][4:0] gcol;
  logic [CHANNELS-1:0]      last_q, last_d;
  logic [CHANNELS-1:0]      err_q, err_d;
  logic [CHANNELS-1:0]      req, pop, hit, enter, tmo;

  // Regroup grants per VC so each FSM sees its own 5-port column
  always_comb begin
    gcol = '0;
    for (int i = 0; i < CHANNELS; i++)
      for (int j = 0; j < 5; j++)
        gcol[i][j] = grant_i[j][i];
  end

  // Per-VC next-state, pop and protocol-error decode
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    last_d  = last_q;
    err_d   = err_q;
    req     = '0;
    pop     = '0;
    hit     = '0;
    enter   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (state_q[i])
        S_IDLE: begin
          if (flit_valid_i[i]) begin
            if (flit_head_i[i] && $onehot(flit_route_i[i])) begin
              route_d[i] = flit_route_i[i];
              last_d[i]  = flit_tail_i[i];
              state_d[i] = S_ACT;
              enter[i]   = 1'b1;
            end else begin
              pop[i]   = 1'b1;
              err_d[i] = 1'b1;
            end
          end
        end
        S_ACT: begin
          req[i] = flit_valid_i[i];
          hit[i] = flit_valid_i[i] && |(gcol[i] & route_q[i]);
          if (hit[i]) begin
            pop[i]     = 1'b1;
            last_d[i]  = flit_tail_i[i];
            state_d[i] = S_REL;
          end
          if (|(gcol[i] & ~route_q[i]) ||
              (|(gcol[i] & route_q[i]) && !flit_valid_i[i]))
            err_d[i] = 1'b1;
        end
        S_REL: begin
          state_d[i] = last_q[i] ? S_IDLE : S_ACT;
          enter[i]   = !last_q[i];
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // State, latched route/tail and sticky error
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q <= '0;
      route_q <= '0;
      last_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      last_q  <= last_d;
      err_q   <= err_d | tmo;
    end
  end

`ifdef NOC_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  logic [CHANNELS-1:0][CW-1:0] cnt_q;

  // Saturating starvation counter; restarts on ACTIVE entry and each grant
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (enter[i] || hit[i])
          cnt_q[i] <= '0;
        else if (req[i] && cnt_q[i] != TMAX)
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  // Flag the cycle in which the counter reaches the limit
  always_comb begin
    tmo = '0;
    for (int i = 0; i < CHANNELS; i++)
      tmo[i] = req[i] && !hit[i] && (cnt_q[i] == TMAX - 1'b1);
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^{TIMEOUT_CYCLES, enter};
  assign tmo = '0;
`endif

  // Outputs: only the latched route row is ever driven per VC
  always_comb begin
    start_of_packet_o = '0;
    request_o         = '0;
    free_o            = '0;
    end_of_packet_o   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      for (int j = 0; j < 5; j++) begin
        start_of_packet_o[j][i] = route_q[i][j] &&
          (state_q[i] == S_ACT || state_q[i] == S_REL);
        request_o[j][i]       = route_q[i][j] && req[i];
        free_o[j][i]          = route_q[i][j] && state_q[i] == S_REL;
        end_of_packet_o[j][i] = route_q[i][j] && state_q[i] == S_REL
                                && last_q[i];
      end
    end
  end

  assign flit_pop_o = pop;
  assign err_o      = err_q;

endmodule

// File: tb/tb_noc_input_port_requester.sv
// Directed bench for noc_input_port_requester, two VCs.
// Expected values are hand-derived per cycle.
module tb_noc_input_port_requester;

  logic           clk;
  logic           rst_n;
  logic [1:0]     valid, head, tail;
  logic [1:0][4:0] route;
  logic [1:0]     pop;
  logic [4:0][1:0] sop, req, grant, free, eop;
  logic [1:0]     err;

  int npass = 0;
  int ntotal = 0;
  int npop, nfree, neop;
  logic [1:0] tmo_exp;

  noc_input_port_requester #(
    .CHANNELS(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .noc_clk(clk),
    .noc_rst_n(rst_n),
    .flit_valid_i(valid),
    .flit_head_i(head),
    .flit_tail_i(tail),
    .flit_route_i(route),
    .flit_pop_o(pop),
    .start_of_packet_o(sop),
    .request_o(req),
    .grant_i(grant),
    .free_o(free),
    .end_of_packet_o(eop),
    .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    ntotal++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      npass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] h,
                       input logic [1:0] t, input logic [9:0] r,
                       input logic [9:0] g);
    valid = v;
    head  = h;
    tail  = t;
    route = r;
    grant = g;
    #1;
  endtask

  initial begin
`ifdef NOC_REQ_TIMEOUT_EN
    tmo_exp = 2'b10;
`else
    tmo_exp = 2'b00;
`endif
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) cyc();
    check("rst_sop", sop, 0);
    check("rst_req", req, 0);
    check("rst_free", free, 0);
    check("rst_eop", eop, 0);
    check("rst_pop", pop, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    // single-flit packet, VC0 -> port 2
    cyc(); drive(2'b01, 2'b01, 2'b01, {5'd0, 5'b00100}, 0);
    check("t1_idle_req", req, 0);
    check("t1_idle_pop", pop, 0);
    cyc(); drive(2'b01, 2'b01, 2'b01, {5'd0, 5'b00100}, 10'h010);
    check("t1_sop", sop, 10'h010);
    check("t1_req", req, 10'h010);
    check("t1_pop", pop, 2'b01);
    cyc(); drive(0, 0, 0, 0, 0);
    check("t1_free", free, 10'h010);
    check("t1_eop", eop, 10'h010);
    check("t1_rel_req", req, 0);
    check("t1_rel_pop", pop, 0);
    cyc();
    check("t1_done_sop", sop, 0);
    check("t1_done_free", free, 0);
    check("t1_done_err", err, 0);

    // 4-flit packet, VC0 -> port 0, grant on every request
    npop = 0; nfree = 0; neop = 0;
    cyc(); drive(2'b01, 2'b01, 2'b00, {5'd0, 5'b00001}, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      drive(2'b01, {1'b0, k == 0}, {1'b0, k == 3}, {5'd0, 5'b00001}, 10'h001);
      check("t2_req", req, 10'h001);
      check("t2_sop", sop, 10'h001);
      npop += int'(pop[0]);
      cyc();
      drive({1'b0, k < 3}, 0, {1'b0, k == 2}, {5'd0, 5'b00001}, 0);
      check("t2_req_gap", req, 0);
      check("t2_sop_held", sop, 10'h001);
      check("t2_eop", eop, (k == 3) ? 10'h001 : 10'h000);
      nfree += int'(free[0][0]);
      neop += int'(eop[0][0]);
    end
    check("t2_npop", npop[15:0], 4);
    check("t2_nfree", nfree[15:0], 4);
    check("t2_neop", neop[15:0], 1);
    cyc();
    check("t2_done_sop", sop, 0);

    // VC0 and VC1 both to port 3, alternating grants
    cyc(); drive(2'b11, 2'b11, 2'b11, {5'b01000, 5'b01000}, 0);
    cyc(); drive(2'b11, 2'b11, 2'b11, {5'b01000, 5'b01000}, 10'h040);
    check("t3_sop_both", sop, 10'h0C0);
    check("t3_req_both", req, 10'h0C0);
    check("t3_pop_vc0", pop, 2'b01);
    cyc(); drive(2'b10, 2'b10, 2'b10, {5'b01000, 5'd0}, 10'h080);
    check("t3_free_vc0", free, 10'h040);
    check("t3_eop_vc0", eop, 10'h040);
    check("t3_req_vc1", req, 10'h080);
    check("t3_pop_vc1", pop, 2'b10);
    cyc(); drive(0, 0, 0, 0, 0);
    check("t3_free_vc1", free, 10'h080);
    check("t3_eop_vc1", eop, 10'h080);
    check("t3_sop_vc1", sop, 10'h080);
    cyc();
    check("t3_done_sop", sop, 0);
    check("t3_done_err", err, 0);

    // stray grant, body flit in IDLE, bad route
    cyc(); drive(2'b01, 2'b01, 2'b00, {5'd0, 5'b00100}, 0);
    cyc(); drive(2'b01, 2'b01, 2'b00, {5'd0, 5'b00100}, 10'h004);
    check("t4_stray_pop", pop, 0);
    cyc(); drive(2'b01, 2'b01, 2'b00, {5'd0, 5'b00100}, 10'h010);
    check("t4_err_stray", err, 2'b01);
    check("t4_pop", pop, 2'b01);
    cyc(); drive(2'b01, 2'b00, 2'b01, {5'd0, 5'b00100}, 0);
    check("t4_free1", free, 10'h010);
    check("t4_eop1", eop, 0);
    cyc(); drive(2'b01, 2'b00, 2'b01, {5'd0, 5'b00100}, 10'h010);
    check("t4_pop_tail", pop, 2'b01);
    cyc(); drive(0, 0, 0, 0, 0);
    check("t4_eop_tail", eop, 10'h010);
    cyc(); drive(2'b01, 2'b00, 2'b00, {5'd0, 5'b00100}, 0);
    check("t4_body_pop", pop, 2'b01);
    cyc(); drive(2'b10, 2'b10, 2'b10, {5'b00011, 5'd0}, 0);
    check("t4_body_sop", sop, 0);
    check("t4_badroute_pop", pop, 2'b10);
    cyc(); drive(0, 0, 0, 0, 0);
    check("t4_err_both", err, 2'b11);
    check("t4_bad_sop", sop, 0);
    repeat (3) cyc();
    check("t4_err_sticky", err, 2'b11);

    // reset after 2 of 4 flits
    cyc(); drive(2'b01, 2'b01, 2'b00, {5'd0, 5'b00001}, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(); drive(2'b01, {1'b0, k == 0}, 0, {5'd0, 5'b00001}, 10'h001);
      cyc(); drive(2'b01, 0, 0, {5'd0, 5'b00001}, 0);
    end
    cyc(); drive(2'b01, 0, 0, {5'd0, 5'b00001}, 0);
    check("t5_req_before", req, 10'h001);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    check("t5_rst_sop", sop, 0);
    check("t5_rst_req", req, 0);
    check("t5_rst_free", free, 0);
    check("t5_rst_eop", eop, 0);
    check("t5_rst_pop", pop, 0);
    check("t5_rst_err", err, 0);
    cyc();
    check("t5_rst_eop2", eop, 0);
    rst_n = 1'b1;
    cyc(); drive(2'b01, 2'b01, 2'b01, {5'd0, 5'b00010}, 0);
    cyc(); drive(2'b01, 2'b01, 2'b01, {5'd0, 5'b00010}, 10'h004);
    check("t5_new_sop", sop, 10'h004);
    check("t5_new_pop", pop, 2'b01);
    cyc(); drive(0, 0, 0, 0, 0);
    check("t5_new_eop", eop, 10'h004);
    cyc();

    // starved request on VC1 -> port 4
    cyc(); drive(2'b10, 2'b10, 2'b10, {5'b10000, 5'd0}, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc(); drive(2'b10, 2'b10, 2'b10, {5'b10000, 5'd0}, 0);
      if (k == 1) check("t6_req", req, 10'h200);
      if (k == 8) check("t6_err_k8", err, 0);
      if (k == 9) check("t6_err_k9", err, tmo_exp);
    end
    cyc(); drive(2'b10, 2'b10, 2'b10, {5'b10000, 5'd0}, 10'h200);
    check("t6_pop", pop, 2'b10);
    cyc(); drive(0, 0, 0, 0, 0);
    check("t6_eop", eop, 10'h200);
    cyc();
    check("t6_err_end", err, tmo_exp);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/noc_input_port_requester.md
# noc_input_port_requester

Input-side counterpart of the per-port control/allocation block in the router. It sits behind each input port's VC buffers and drives the control interface toward the five output port controllers. For every VC it takes the head flit's precomputed one-hot route, raises packet-start and per-flit requests toward the selected output, pops a flit on each grant, and signals flit release and packet end back to the allocator.

## Interface
- `CHANNELS`, default `Noc_VC_Channel`: number of virtual channels, at least 1.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit. Used only when `NOC_REQ_TIMEOUT_EN` is defined.
---
- `noc_clk`, in, 1: clock. Single clock domain.
- `noc_rst_n`, in, 1: asynchronous, active-low reset.
- `flit_valid_i`, in, [CHANNELS]: a head-of-buffer flit is present on VC i.
- `flit_head_i`, in, [CHANNELS]: the current flit is a head flit.
- `flit_tail_i`, in, [CHANNELS]: the current flit is a tail flit. Head and tail together mark a single-flit packet.
- `flit_route_i`, in, [CHANNELS][5]: one-hot output port. Meaningful only on a head flit.
- `flit_pop_o`, out, [CHANNELS]: dequeue the current flit of VC i.
- `start_of_packet_o`, out, [5][CHANNELS]: port-arbitration request toward output port j for VC i.
- `request_o`, out, [5][CHANNELS]: per-flit VC-arbitration request.
- `grant_i`, in, [5][CHANNELS]: grant from output port j for VC i.
- `free_o`, out, [5][CHANNELS]: flit-transfer-complete pulse.
- `end_of_packet_o`, out, [5][CHANNELS]: packet-complete pulse. Releases the port arbiter.
- `err_o`, out, [CHANNELS]: sticky protocol-error flag. Cleared only by reset.

## Operation
Each VC has an independent FSM with states IDLE, ACTIVE and RELEASE.

- **IDLE**
  - If `flit_valid_i` and `flit_head_i` are high and `flit_route_i` is one-hot: latch the route into `route_q` and the tail bit, then go to ACTIVE.
  - If the route is not one-hot: pop and discard the flit, set `err_o`, stay in IDLE.
  - If a non-head valid flit is present: pop and discard it, set `err_o`, stay in IDLE.
- **ACTIVE**
  - `start_of_packet_o[route_q][i]` is held at 1.
  - `request_o[route_q][i]` equals `flit_valid_i[i]`.
  - When `grant_i[route_q][i]` is high and the request is high in the same cycle:
    - `flit_pop_o[i]` is 1 combinationally in that cycle.
    - Latch the flit's tail bit into `last_q`.
    - Go to RELEASE.
  - A grant on any other port, or a grant while not requesting, is ignored and sets `err_o`.
- **RELEASE** (one cycle)
  - `free_o[route_q][i]` is 1.
  - `end_of_packet_o[route_q][i]` equals `last_q`.
  - `start_of_packet_o` stays held until the tail's RELEASE cycle, inclusive.
  - `request_o` is 0.
  - Next state is IDLE if `last_q` is set, otherwise ACTIVE.
- Only port `route_q` is ever driven for a given VC. All other rows are 0.
- VCs never interact. Several VCs may be in different states and may target the same port simultaneously.

## Timing
- **Reset:** every VC is in IDLE; `route_q`, `last_q` and `err_o` are 0; all outputs are 0.
  - Reset asserted mid-packet aborts the packet with no `free_o`/`end_of_packet_o` emitted.
- **Head latency:** a head visible at cycle t gives `start_of_packet_o` and `request_o` at t+1.
- **Grant response:** a grant at cycle t gives the pop at t, `free_o` at t+1, and a renewed request at t+2.
  - Peak rate is therefore one flit per 2 cycles per VC.
  - `request_o` is low in the cycle after a grant, which prevents a double grant through the arbiter's held result.
- **Tail:** `end_of_packet_o` and `free_o` coincide in the tail's RELEASE cycle. A new head can be accepted from IDLE at t+2.
- **Bubbles:** when the buffer is empty in ACTIVE, `request_o` drops and `start_of_packet_o` stays held.
- **Output timing:** state-derived outputs (`start_of_packet_o`, `free_o`, `end_of_packet_o`, `err_o`) are registered. `request_o` and `flit_pop_o` may depend combinationally on `flit_valid_i` and `grant_i`.

## Configuration
- **`NOC_REQ_TIMEOUT_EN` defined:**
  - Each VC has a counter that resets on entry to ACTIVE and on each grant, and increments each cycle in ACTIVE while `request_o` is high and no grant arrives.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`. The counter saturates.
  - Reaching `TIMEOUT_CYCLES` sets `err_o[i]`. The FSM is unaffected.
- **Not defined:** no counter logic exists, and `err_o` reflects only protocol errors.

## Test plan
- **Single-flit packet:** head+tail on VC0, route 5'b00100, `grant_i[2][0]` given the cycle after request.
  - `flit_pop_o[0]`=1 in the grant cycle.
  - `free_o[2][0]`=1 and `end_of_packet_o[2][0]`=1 next cycle.
  - FSM back in IDLE; nothing else asserted.
- **4-flit packet:** route 5'b00001, grant on every request.
  - Exactly 4 pops, 4 `free_o` pulses and 1 `end_of_packet_o` (on the 4th).
  - `start_of_packet_o[0][0]` held continuously; `request_o` low every other cycle.
- **Two VCs to the same port:** VC0 and VC1 both route to port 3, grants alternate.
  - Both packets complete and each VC's outputs appear only in its own column.
  - No cross-VC pops.
- **Stray grant and bad head:** grant on port 1 while routed to port 2, and a body flit arriving in IDLE.
  - No pop for the stray grant; the body flit is discarded.
  - `err_o`=1 and remains 1 until reset.
- **Reset mid-packet:** assert `noc_rst_n`=0 after 2 of 4 flits.
  - All outputs 0 immediately; no `end_of_packet_o`.
  - A new head after release is accepted normally.
- **Timeout (with `NOC_REQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** request held with no grant.
  - `err_o` rises after 8 cycles.
  - Under the same stimulus without the macro, `err_o` stays 0.
